// File: rtl/program_loader.sv
// Boot-time program loader: parses a framed byte stream, writes little-endian 32-bit words into
// program memory and releases the core only after a frame with a matching XOR checksum.
module program_loader #(
  parameter int unsigned INSTR_ADDR_WIDTH = 10,
  parameter int unsigned TIMEOUT          = 1000000
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        reload,
  input  logic                        rx_valid,
  input  logic [7:0]                  rx_data,
  output logic                        rx_ready,
  output logic                        pgm,
  output logic                        pgm_we,
  output logic [INSTR_ADDR_WIDTH-1:0] pgm_addr,
  output logic [31:0]                 pgm_data,
  output logic                        core_hold,
  output logic                        done,
  output logic                        error
);

  localparam logic [7:0]  Magic    = 8'hA5;
  localparam int unsigned MaxWords = 2 ** INSTR_ADDR_WIDTH;
  localparam int unsigned IdleW    = $clog2(TIMEOUT + 1);
  localparam int unsigned AddrW    = INSTR_ADDR_WIDTH;

  typedef enum logic [2:0] {
    StIdle, StLen0, StLen1, StData, StCsum, StDone, StErr
  } state_e;

  state_e             state_q, state_d;
  logic [7:0]         len_lo_q, len_lo_d;
  logic [15:0]        remain_q, remain_d;
  logic [AddrW-1:0]   word_idx_q, word_idx_d;
  logic [1:0]         byte_cnt_q, byte_cnt_d;
  logic [23:0]        word_q, word_d;
  logic [7:0]         xor_q, xor_d;
  logic [IdleW-1:0]   idle_q, idle_d;
  logic               pgm_we_q, pgm_we_d;
  logic [AddrW-1:0]   pgm_addr_q, pgm_addr_d;
  logic [31:0]        pgm_data_q, pgm_data_d;
  logic               done_q, done_d;
  logic               error_q, error_d;

  logic        accept;
  logic        timed;
  logic [15:0] count;

  assign timed  = (state_q == StLen0) || (state_q == StLen1) ||
                  (state_q == StData) || (state_q == StCsum);
  assign accept = rx_valid && rx_ready;
  assign count  = {rx_data, len_lo_q};

  always_comb begin
    state_d    = state_q;
    len_lo_d   = len_lo_q;
    remain_d   = remain_q;
    word_idx_d = word_idx_q;
    byte_cnt_d = byte_cnt_q;
    word_d     = word_q;
    xor_d      = xor_q;
    idle_d     = idle_q;
    pgm_we_d   = 1'b0;
    pgm_addr_d = pgm_addr_q;
    pgm_data_d = pgm_data_q;

    if (reload) begin
      state_d    = StIdle;
      word_idx_d = '0;
      byte_cnt_d = '0;
      xor_d      = '0;
      idle_d     = '0;
    end else begin
      unique case (state_q)
        StIdle, StErr: begin
          if (accept && rx_data == Magic) begin
            state_d    = StLen0;
            word_idx_d = '0;
            byte_cnt_d = '0;
            xor_d      = '0;
          end
        end
        StLen0: begin
          if (accept) begin
            len_lo_d = rx_data;
            xor_d    = rx_data;
            state_d  = StLen1;
          end
        end
        StLen1: begin
          if (accept) begin
            xor_d    = xor_q ^ rx_data;
            remain_d = count;
            if (32'(count) > MaxWords) state_d = StErr;
            else if (count == 16'd0)   state_d = StCsum;
            else                       state_d = StData;
          end
        end
        StData: begin
          if (accept) begin
            xor_d      = xor_q ^ rx_data;
            word_d     = {rx_data, word_q[23:8]};
            byte_cnt_d = byte_cnt_q + 2'd1;
            if (byte_cnt_q == 2'd3) begin
              pgm_we_d   = 1'b1;
              pgm_addr_d = word_idx_q;
              pgm_data_d = {rx_data, word_q};
              word_idx_d = word_idx_q + AddrW'(1);
              remain_d   = remain_q - 16'd1;
              if (remain_q == 16'd1) state_d = StCsum;
            end
          end
        end
        StCsum: begin
          if (accept) state_d = (rx_data == xor_q) ? StDone : StErr;
        end
        StDone: ;
        default: state_d = StIdle;
      endcase

      // An accepted byte always beats an expiring timeout.
      if (timed && !accept) begin
        if (idle_q == IdleW'(TIMEOUT - 1)) begin
          state_d = StErr;
          idle_d  = '0;
        end else begin
          idle_d = idle_q + IdleW'(1);
        end
      end
      if (accept || state_d != state_q) idle_d = '0;
    end

    done_d  = (state_d == StDone);
    error_d = (state_d == StErr);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StIdle;
      len_lo_q   <= '0;
      remain_q   <= '0;
      word_idx_q <= '0;
      byte_cnt_q <= '0;
      word_q     <= '0;
      xor_q      <= '0;
      idle_q     <= '0;
      pgm_we_q   <= 1'b0;
      pgm_addr_q <= '0;
      pgm_data_q <= '0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_lo_q   <= len_lo_d;
      remain_q   <= remain_d;
      word_idx_q <= word_idx_d;
      byte_cnt_q <= byte_cnt_d;
      word_q     <= word_d;
      xor_q      <= xor_d;
      idle_q     <= idle_d;
      pgm_we_q   <= pgm_we_d;
      pgm_addr_q <= pgm_addr_d;
      pgm_data_q <= pgm_data_d;
      done_q     <= done_d;
      error_q    <= error_d;
    end
  end

  assign rx_ready  = (state_q != StDone);
  assign pgm       = timed;
  assign core_hold = (state_q != StDone);
  assign pgm_we    = pgm_we_q;
  assign pgm_addr  = pgm_addr_q;
  assign pgm_data  = pgm_data_q;
  assign done      = done_q;
  assign error     = error_q;

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: good/bad/oversize/empty frames, timeout, reload and reset.
module tb_program_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        reload;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_ready;
  logic        pgm;
  logic        pgm_we;
  logic [9:0]  pgm_addr;
  logic [31:0] pgm_data;
  logic        core_hold;
  logic        done;
  logic        error;

  int vectors = 0;
  int miscompares = 0;

  logic [7:0]  stim[$];
  int          wr_n = 0;
  logic [9:0]  wr_addr[64];
  logic [31:0] wr_data[64];
  int          base;

  program_loader #(
    .INSTR_ADDR_WIDTH(10),
    .TIMEOUT(16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .reload(reload),
    .rx_valid(rx_valid),
    .rx_data(rx_data),
    .rx_ready(rx_ready),
    .pgm(pgm),
    .pgm_we(pgm_we),
    .pgm_addr(pgm_addr),
    .pgm_data(pgm_data),
    .core_hold(core_hold),
    .done(done),
    .error(error)
  );

  always #5 clk = ~clk;

  // pgm_we is a one-cycle pulse, so each write is seen on exactly one falling edge.
  always @(negedge clk) begin
    if (pgm_we === 1'b1 && wr_n < 64) begin
      wr_addr[wr_n] = pgm_addr;
      wr_data[wr_n] = pgm_data;
      wr_n++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed no finish, expected finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Sends every byte in stim, with gap idle cycles after each one.
  task automatic send_q(input int gap);
    foreach (stim[i]) begin
      rx_valid = 1'b1;
      rx_data  = stim[i];
      @(posedge clk); #1;
      rx_valid = 1'b0;
      repeat (gap) @(posedge clk);
      if (gap > 0) #1;
    end
  endtask

  task automatic pulse_reload();
    reload = 1'b1;
    @(posedge clk); #1;
    reload = 1'b0;
  endtask

  initial begin
    rst = 1'b0; reload = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
    #12;
    // {rx_ready,pgm,pgm_we,core_hold,done,error}, addr, data
    chk("reset_flags", {58'd0, rx_ready, pgm, pgm_we, core_hold, done, error}, 64'b100100);
    chk("reset_addr", {54'd0, pgm_addr}, 64'd0);
    chk("reset_data", {32'd0, pgm_data}, 64'd0);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;

    // Good frame at full rate, checking the write pulses as they happen.
    base = wr_n;
    stim = {8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00};
    send_q(0);
    chk("pgm_in_frame", {63'd0, pgm}, 64'd1);
    stim = {8'h00};
    send_q(0);
    chk("w0_we", {63'd0, pgm_we}, 64'd1);
    chk("w0_addr_data", {22'd0, pgm_addr, pgm_data}, {22'd0, 10'd0, 32'h13});
    stim = {8'h6F, 8'h00, 8'h00, 8'h00};
    send_q(0);
    chk("w1_we_csum", {62'd0, pgm_we, pgm}, 64'b11);
    chk("w1_addr_data", {22'd0, pgm_addr, pgm_data}, {22'd0, 10'd1, 32'h6F});
    stim = {8'h7E};
    send_q(0);
    chk("good_done", {60'd0, done, error, core_hold, rx_ready}, 64'b1000);
    chk("good_nwr", 64'(wr_n - base), 64'd2);
    // DONE back-pressures; an offered byte must not change anything.
    rx_valid = 1'b1; rx_data = 8'hA5;
    @(posedge clk); #1;
    rx_valid = 1'b0;
    chk("done_holds", {61'd0, done, pgm, rx_ready}, 64'b100);

    // Reload in DONE, then a bad checksum frame.
    pulse_reload();
    chk("reload_idle", {60'd0, core_hold, done, pgm, rx_ready}, 64'b1001);
    base = wr_n;
    stim = {8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
            8'h6F, 8'h00, 8'h00, 8'h00, 8'h7F};
    send_q(0);
    chk("bad_err", {61'd0, error, core_hold, done}, 64'b110);
    chk("bad_nwr", 64'(wr_n - base), 64'd2);
    chk("bad_w0", {22'd0, wr_addr[base], wr_data[base]}, {22'd0, 10'd0, 32'h13});

    // Good frame directly from ERR.
    base = wr_n;
    stim = {8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
            8'h6F, 8'h00, 8'h00, 8'h00, 8'h7E};
    send_q(0);
    chk("recover_done", {62'd0, done, error}, 64'b10);
    chk("recover_w0", {22'd0, wr_addr[base], wr_data[base]}, {22'd0, 10'd0, 32'h13});
    chk("recover_w1", {22'd0, wr_addr[base+1], wr_data[base+1]}, {22'd0, 10'd1, 32'h6F});

    // Oversize count 1025, then empty frame.
    pulse_reload();
    base = wr_n;
    stim = {8'hA5, 8'h01, 8'h04};
    send_q(0);
    chk("oversize_err", {62'd0, error, pgm}, 64'b10);
    stim = {8'hA5, 8'h00, 8'h00, 8'h00};
    send_q(0);
    chk("empty_done", {61'd0, done, error, core_hold}, 64'b100);
    chk("size_nwr", 64'(wr_n - base), 64'd0);

    // Timeout after LEN_L.
    pulse_reload();
    stim = {8'hA5, 8'h02};
    send_q(0);
    repeat (15) @(posedge clk);
    #1;
    chk("tmo_15", {62'd0, error, pgm}, 64'b01);
    @(posedge clk); #1;
    chk("tmo_16", {62'd0, error, pgm}, 64'b10);

    // Gaps of 15 idle cycles between bytes must not time out.
    base = wr_n;
    stim = {8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
            8'h6F, 8'h00, 8'h00, 8'h00, 8'h7E};
    send_q(15);
    chk("gap_done", {62'd0, done, error}, 64'b10);
    chk("gap_w1", {22'd0, wr_addr[base+1], wr_data[base+1]}, {22'd0, 10'd1, 32'h6F});

    // Reset in the middle of a word.
    pulse_reload();
    base = wr_n;
    stim = {8'hA5, 8'h02, 8'h00, 8'h13, 8'h00};
    send_q(0);
    rst = 1'b0;
    #1;
    chk("rst_flags", {58'd0, rx_ready, pgm, pgm_we, core_hold, done, error}, 64'b100100);
    chk("rst_addr_data", {22'd0, pgm_addr, pgm_data}, 64'd0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rst_nwr", 64'(wr_n - base), 64'd0);

    // Noise in IDLE, then a good frame.
    stim = {8'h00};
    send_q(0);
    chk("noise0_ready", {62'd0, rx_ready, pgm}, 64'b10);
    stim = {8'hFF};
    send_q(0);
    chk("noise1_ready", {62'd0, rx_ready, pgm}, 64'b10);
    stim = {8'h13};
    send_q(0);
    chk("noise2_ready", {62'd0, rx_ready, pgm}, 64'b10);
    base = wr_n;
    stim = {8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
            8'h6F, 8'h00, 8'h00, 8'h00, 8'h7E};
    send_q(0);
    chk("noise_done", {61'd0, done, error, core_hold}, 64'b100);
    chk("noise_w0", {22'd0, wr_addr[base], wr_data[base]}, {22'd0, 10'd0, 32'h13});
    chk("noise_w1", {22'd0, wr_addr[base+1], wr_data[base+1]}, {22'd0, 10'd1, 32'h6F});
    chk("noise_nwr", 64'(wr_n - base), 64'd2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
